// File: rtl/result_bcd_converter.sv
// result_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   for the calculator result feeding the SSD/VGA display logic.
//
// Ports:
//   Clk     system clock
//   Reset   synchronous, active-high reset
//   Start   request a conversion (sampled only in QI)
//   Ack     consumer acknowledges the result (sampled only in QDone)
//   Bin     value to convert, captured on the Start-accepting edge
//   Signed  treat Bin as two's complement, captured with Bin
//   Bcd     DIGITS packed BCD digits, digit 0 (units) in the low nibble
//   Neg     result is negative
//   Blank   leading-zero blank mask, bit 0 always 0
//   Done    high throughout QDone
//   QI, QShift, QDone  one-hot state indicators
module result_bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Ack,
  input  logic [BIN_W-1:0]      Bin,
  input  logic                  Signed,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic                  Neg,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Done,
  output logic                  QI,
  output logic                  QShift,
  output logic                  QDone
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [BIN_W-1:0]     shreg;
  logic [4*DIGITS-1:0]  scratch;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_pend;

  logic [BIN_W-1:0]     mag;
  logic [4*DIGITS-1:0]  corr;
  logic [SR_W-1:0]      shifted;

  // Add 3 to every digit >= 5 so the following left shift carries correctly
  // into the next decimal digit.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Bit i set when digit i and every digit above it are zero; units never blank.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] b;
    logic              all_zero;
    b        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      all_zero = all_zero & (d[4*i +: 4] == 4'd0);
      b[i]     = all_zero;
    end
    return b;
  endfunction

  // Negation of the most negative value yields the same bit pattern, which
  // read as unsigned is exactly the wanted magnitude (e.g. 0x8000 -> 32768).
  always_comb begin
    mag = Bin;
    if (Signed && Bin[BIN_W-1])
      mag = (~Bin) + {{(BIN_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    corr    = add3(scratch);
    shifted = {corr, shreg} << 1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      Bcd    <= '0;
      Neg    <= 1'b0;
      Blank  <= BLANK_RST;
      Done   <= 1'b0;
      QI     <= 1'b1;
      QShift <= 1'b0;
      QDone  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            shreg    <= mag;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W-1);
            neg_pend <= Signed & Bin[BIN_W-1];
            state    <= S_SHIFT;
            QI       <= 1'b0;
            QShift   <= 1'b1;
          end
        end
        S_SHIFT: begin
          {scratch, shreg} <= shifted;
          if (cnt == '0) begin
            state  <= S_DONE;
            QShift <= 1'b0;
            QDone  <= 1'b1;
            Done   <= 1'b1;
            Bcd    <= shifted[BIN_W +: 4*DIGITS];
            // A zero magnitude is never reported as negative.
            Neg    <= neg_pend & (|shifted[BIN_W +: 4*DIGITS]);
            Blank  <= blank_mask(shifted[BIN_W +: 4*DIGITS]);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Ack wins over a simultaneous Start; a fresh Start in QI is needed.
          if (Ack) begin
            state <= S_IDLE;
            QDone <= 1'b0;
            Done  <= 1'b0;
            QI    <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          Done   <= 1'b0;
          QI     <= 1'b1;
          QShift <= 1'b0;
          QDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Ack;
  logic [15:0] Bin;
  logic        Signed;
  logic [19:0] Bcd;
  logic        Neg;
  logic [4:0]  Blank;
  logic        Done;
  logic        QI;
  logic        QShift;
  logic        QDone;

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic [4:0]  blank;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  result_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Bin(Bin),
    .Signed(Signed), .Bcd(Bcd), .Neg(Neg), .Blank(Blank), .Done(Done),
    .QI(QI), .QShift(QShift), .QDone(QDone)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude range.
  function automatic exp_t model(input logic [15:0] b, input logic s);
    exp_t e;
    int   mag;
    int   p;
    mag = (s && b[15]) ? (65536 - int'(b)) : int'(b);
    e.bcd   = '0;
    e.blank = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'((mag / p) % 10);
      if (i >= 1) e.blank[i] = (mag < p);
      p = p * 10;
    end
    e.neg = s && b[15] && (mag != 0);
    return e;
  endfunction

  // mode 0: normal with Ack; 1: leave in QDone; 2: Start/Bin disturbed mid-QShift
  task automatic run_conv(input logic [15:0] b, input logic s, input int mode);
    int   lat;
    int   w;
    exp_t e;
    w = 0;
    while (!QI && w < 40) begin
      @(negedge Clk);
      w++;
    end
    if (!QI) chk("idle_wait", 32'(QI), 32'd1);
    @(negedge Clk);
    Bin = b; Signed = s; Start = 1'b1;
    q.push_back(model(b, s));
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    Start = 1'b0;
    while (!Done && lat < 40) begin
      if (mode == 2 && lat == 5) begin
        Start = 1'b1; Bin = ~b; Signed = ~s;
      end
      if (mode == 2 && lat == 6) Start = 1'b0;
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("latency", 32'(lat), 32'd17);
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("bcd", 32'(Bcd), 32'(e.bcd));
      chk("neg", 32'(Neg), 32'(e.neg));
      chk("blank", 32'(Blank), 32'(e.blank));
    end
    if (mode != 1) begin
      chk("qdone", {29'd0, QI, QShift, QDone}, 32'b001);
      Ack = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Ack = 1'b0;
      chk("after_ack", {28'd0, Done, QI, QShift, QDone}, 32'b0100);
    end
  endtask

  initial begin
    int   dz;
    exp_t e;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Bin = '0; Signed = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_state", {28'd0, Done, QI, QShift, QDone}, 32'b0100);
    chk("rst_bcd", 32'(Bcd), 32'd0);
    chk("rst_neg", 32'(Neg), 32'd0);
    chk("rst_blank", 32'(Blank), 32'b11110);
    Reset = 1'b0;

    // Ack outside QDone is ignored
    Ack = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Ack = 1'b0;
    chk("ack_in_idle", {29'd0, QI, QShift, QDone}, 32'b100);

    run_conv(16'h0000, 1'b0, 0);
    run_conv(16'hFFFF, 1'b0, 0);
    run_conv(16'hFFFF, 1'b1, 0);
    run_conv(16'h8000, 1'b1, 0);
    run_conv(16'h0123, 1'b0, 0);
    run_conv(16'h7FFF, 1'b1, 0);
    run_conv(16'h8001, 1'b1, 0);
    run_conv(16'd9999, 1'b0, 0);
    run_conv(16'd10000, 1'b0, 0);
    run_conv(16'd9, 1'b0, 0);
    run_conv(16'd10, 1'b0, 0);

    // Start pulsed mid-QShift with different Bin/Signed
    run_conv(16'd4321, 1'b0, 2);

    // Ack and Start together in QDone
    run_conv(16'd777, 1'b0, 1);
    Ack = 1'b1; Start = 1'b1; Bin = 16'd5; Signed = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Ack = 1'b0; Start = 1'b0;
    chk("ackstart_qi", {28'd0, Done, QI, QShift, QDone}, 32'b0100);
    @(posedge Clk);
    @(negedge Clk);
    chk("ackstart_nostart", {29'd0, QI, QShift, QDone}, 32'b100);
    e = model(16'd777, 1'b0);
    chk("ackstart_hold", 32'(Bcd), 32'(e.bcd));

    // Reset at QShift cycle 8
    @(negedge Clk);
    Bin = 16'h1234; Signed = 1'b0; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    chk("pre_rst_shift", 32'(QShift), 32'd1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_state", {28'd0, Done, QI, QShift, QDone}, 32'b0100);
    chk("midrst_bcd", 32'(Bcd), 32'd0);
    chk("midrst_neg", 32'(Neg), 32'd0);
    chk("midrst_blank", 32'(Blank), 32'b11110);
    dz = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done) dz++;
    end
    chk("midrst_done_low", 32'(dz), 32'd0);

    // Randomised sweep, unsigned then signed
    for (int i = 0; i < 500; i++) run_conv(16'($urandom_range(0, 65535)), 1'b0, 0);
    for (int i = 0; i < 500; i++) run_conv(16'($urandom_range(0, 65535)), 1'b1, 0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
